axis_adder_tree_nch: RTL and testbench

Parametrised N-operand AXI-Stream adder, successor to the two-operand pipelined AXIS adder. It joins NUM_OPERANDS slave streams, sums one beat from each through a registered binary adder tree, and drives one master result stream. Signed/unsigned and wrap/saturate modes are selectable, and full throughput of one beat per cycle is held under backpressure.

---
 rtl/axis_adder_pkg.sv | 67 ++++++
 rtl/adder_tree_level.sv | 61 ++++++
 rtl/axis_adder_tree_nch.sv | 99 +++++++++
 tb/tb_axis_adder_tree_nch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_adder_pkg.sv
// Shared types and width/arithmetic helpers for the N-operand AXIS adder tree.
package axis_adder_pkg;

  // Sideband carried alongside each partial-sum beat through the tree.
  typedef struct packed {
    logic valid;
    logic last;
    logic mismatch;
  } sb_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Node count after lvl pairwise reductions of n leaves.
  function automatic int unsigned nodes_at(input int unsigned n, input int unsigned lvl);
    int unsigned m;
    m = n;
    for (int unsigned i = 0; i < lvl; i++) m = (m + 1) / 2;
    return m;
  endfunction

  // Result width: clamped to operand width, or full precision.
  function automatic int unsigned result_width(input int unsigned w, input int unsigned n,
                                               input int unsigned sat);
    return (sat != 0) ? w : w + clog2(n);
  endfunction

  // AXIS byte-aligned bus width for a payload of w bits.
  function automatic int unsigned axis_width(input int unsigned w);
    return ((w + 7) / 8) * 8;
  endfunction

  // Keep the low w bits of x and extend them to 64 bits (sign or zero).
  function automatic logic [63:0] ext64(input logic [63:0] x, input int unsigned w,
                                        input logic sgn);
    logic [63:0] mask;
    logic        msb;
    mask = (64'd1 << w) - 64'd1;
    msb  = x[6'(w - 1)];
    return (sgn && msb) ? (x | ~mask) : (x & mask);
  endfunction

  // Clamp a 64-bit extended value into the w-bit signed or unsigned range.
  function automatic logic [63:0] sat_clamp(input logic [63:0] x, input int unsigned w,
                                            input logic sgn);
    logic signed [63:0] xs;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    xs = signed'(x);
    if (sgn) begin
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
    end else begin
      hi = (64'sd1 <<< w) - 64'sd1;
      lo = 64'sd0;
    end
    if (xs > hi) return unsigned'(hi);
    if (xs < lo) return unsigned'(lo);
    return x;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: pairwise sums plus a valid/advance slot.
module adder_tree_level
  import axis_adder_pkg::*;
#(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned WS    = 9,
  parameter logic        SGN   = 1'b0,
  parameter int unsigned SAT_W = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_IN*WS-1:0]            in_data_i,
  input  sb_t                           in_sb_i,
  input  logic                          next_load_i,
  output logic                          free_c_o,
  output logic                          load_c_o,
  output logic [((N_IN+1)/2)*WS-1:0]    out_data_o,
  output sb_t                           out_sb_o
);

  localparam int unsigned N_OUT = (N_IN + 1) / 2;
  localparam int unsigned CLAMP_W = (SAT_W == 0) ? 1 : SAT_W;

  logic [N_OUT*WS-1:0] sum_d;
  logic [N_OUT*WS-1:0] data_q;
  sb_t                 sb_q;

  // Pair adjacent nodes; an unpaired last node passes through unchanged.
  for (genvar j = 0; j < N_OUT; j++) begin : g_node
    logic [WS-1:0] raw;
    logic [WS-1:0] clamped;
    if (2 * j + 1 < N_IN) begin : g_pair
      assign raw = in_data_i[2*j*WS +: WS] + in_data_i[(2*j+1)*WS +: WS];
    end else begin : g_pass
      assign raw = in_data_i[2*j*WS +: WS];
    end
    assign clamped = WS'(sat_clamp(ext64(64'(raw), WS, SGN), CLAMP_W, SGN));
    assign sum_d[j*WS +: WS] = (SAT_W == 0) ? raw : clamped;
  end

  // An empty slot always accepts; a full one only when its content moves on.
  assign free_c_o = !sb_q.valid || next_load_i;
  assign load_c_o = in_sb_i.valid && free_c_o;

  // Stage register: capture new beat, or drop valid once downstream took it.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      data_q <= '0;
      sb_q   <= '0;
    end else if (load_c_o) begin
      data_q <= sum_d;
      sb_q   <= in_sb_i;
    end else if (next_load_i) begin
      sb_q.valid <= 1'b0;
    end
  end

  assign out_data_o = data_q;
  assign out_sb_o   = sb_q;

endmodule

// File: rtl/axis_adder_tree_nch.sv
// N-operand AXI-Stream join-and-sum through a registered binary adder tree.
module axis_adder_tree_nch
  import axis_adder_pkg::*;
#(
  parameter int unsigned NUM_OPERANDS = 4,
  parameter int unsigned ADDER_WIDTH  = 8,
  parameter int unsigned SIGNED       = 0,
  parameter int unsigned SATURATE     = 0,
  localparam int unsigned LEVELS         = clog2(NUM_OPERANDS),
  localparam int unsigned RESULT_WIDTH   = result_width(ADDER_WIDTH, NUM_OPERANDS, SATURATE),
  localparam int unsigned IN_AXIS_WIDTH  = axis_width(ADDER_WIDTH),
  localparam int unsigned OUT_AXIS_WIDTH = axis_width(RESULT_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_OPERANDS*IN_AXIS_WIDTH-1:0] s_tdata,
  input  logic [NUM_OPERANDS-1:0]             s_tvalid,
  output logic [NUM_OPERANDS-1:0]             s_tready,
  input  logic [NUM_OPERANDS-1:0]             s_tlast,
  output logic [OUT_AXIS_WIDTH-1:0]           m_tdata,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic                                m_tlast,
  output logic                                err_last_mismatch
);

  localparam int unsigned SUM_W = ADDER_WIDTH + LEVELS;
  localparam logic        SGN   = (SIGNED != 0);
  localparam int unsigned SAT_W = (SATURATE != 0) ? ADDER_WIDTH : 0;

  logic                          fire_c;
  logic                          mismatch_c;
  logic [NUM_OPERANDS*SUM_W-1:0] op_ext_c;
  sb_t                           sb_c [LEVELS+1];
  logic [LEVELS:0]               load_c;
  logic [LEVELS-1:0]             free_c;
  logic [SUM_W-1:0]              result_c;
  logic                          err_q;
  logic                          unused_c;

  // Drop AXIS pad bits and widen each operand to the full-precision sum width.
  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_op
    assign op_ext_c[k*SUM_W +: SUM_W] =
      SUM_W'(ext64(64'(s_tdata[k*IN_AXIS_WIDTH +: ADDER_WIDTH]), ADDER_WIDTH, SGN));
  end

  // Join: every channel valid and the first stage able to take the beat.
  assign fire_c     = !rstn && (&s_tvalid) && free_c[0];
  assign mismatch_c = (|s_tlast) && !(&s_tlast);
  assign s_tready   = {NUM_OPERANDS{load_c[0]}};

  assign sb_c[0]        = '{valid: fire_c, last: s_tlast[0], mismatch: mismatch_c};
  assign load_c[LEVELS] = m_tready;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned NI = nodes_at(NUM_OPERANDS, l);
    localparam int unsigned NO = nodes_at(NUM_OPERANDS, l + 1);
    logic [NI*SUM_W-1:0] in_data;
    logic [NO*SUM_W-1:0] out_data;
    if (l == 0) begin : g_first
      assign in_data = op_ext_c;
    end else begin : g_next
      assign in_data = g_lvl[l-1].out_data;
    end
    adder_tree_level #(
      .N_IN  (NI),
      .WS    (SUM_W),
      .SGN   (SGN),
      .SAT_W ((l == LEVELS - 1) ? SAT_W : 0)
    ) u_level (
      .clk         (clk),
      .rstn        (rstn),
      .in_data_i   (in_data),
      .in_sb_i     (sb_c[l]),
      .next_load_i (load_c[l+1]),
      .free_c_o    (free_c[l]),
      .load_c_o    (load_c[l]),
      .out_data_o  (out_data),
      .out_sb_o    (sb_c[l+1])
    );
  end

  assign result_c = g_lvl[LEVELS-1].out_data;

  // Result pad bits follow the result's signedness.
  assign m_tdata  = OUT_AXIS_WIDTH'(ext64(64'(result_c), RESULT_WIDTH, SGN));
  assign m_tvalid = sb_c[LEVELS].valid;
  assign m_tlast  = sb_c[LEVELS].last;

  // Non-uniform tlast flagged on the accepting edge, regardless of output stall.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) err_q <= 1'b0;
    else      err_q <= fire_c && mismatch_c;
  end

  assign err_last_mismatch = err_q;
  assign unused_c = ^{s_tdata, free_c, sb_c[LEVELS].mismatch};

endmodule

// File: tb/tb_axis_adder_tree_nch.sv
// Randomized and directed checks of axis_adder_tree_nch against an arithmetic model.
module tb_axis_adder_tree_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // A: N=4 W=8 unsigned wrap
  logic [31:0] a_tdata;  logic [3:0] a_tvalid, a_tready, a_tlast;
  logic [15:0] a_mdata;  logic a_mvalid, a_mready, a_mlast, a_err;
  // B: N=3 W=8 signed wrap
  logic [23:0] b_tdata;  logic [2:0] b_tvalid, b_tready;
  logic [15:0] b_mdata;  logic b_mvalid, b_mlast, b_err;
  // C: N=4 W=8 signed saturate
  logic [31:0] c_tdata;  logic [3:0] c_tvalid, c_tready;
  logic [7:0]  c_mdata;  logic c_mvalid, c_mlast, c_err;
  // D: N=2 W=8 unsigned saturate
  logic [15:0] d_tdata;  logic [1:0] d_tvalid, d_tready;
  logic [7:0]  d_mdata;  logic d_mvalid, d_mlast, d_err;

  axis_adder_tree_nch #(.NUM_OPERANDS(4), .ADDER_WIDTH(8), .SIGNED(0), .SATURATE(0)) u_a (
    .clk(clk), .rstn(rstn), .s_tdata(a_tdata), .s_tvalid(a_tvalid), .s_tready(a_tready),
    .s_tlast(a_tlast), .m_tdata(a_mdata), .m_tvalid(a_mvalid), .m_tready(a_mready),
    .m_tlast(a_mlast), .err_last_mismatch(a_err));
  axis_adder_tree_nch #(.NUM_OPERANDS(3), .ADDER_WIDTH(8), .SIGNED(1), .SATURATE(0)) u_b (
    .clk(clk), .rstn(rstn), .s_tdata(b_tdata), .s_tvalid(b_tvalid), .s_tready(b_tready),
    .s_tlast(3'b000), .m_tdata(b_mdata), .m_tvalid(b_mvalid), .m_tready(1'b1),
    .m_tlast(b_mlast), .err_last_mismatch(b_err));
  axis_adder_tree_nch #(.NUM_OPERANDS(4), .ADDER_WIDTH(8), .SIGNED(1), .SATURATE(1)) u_c (
    .clk(clk), .rstn(rstn), .s_tdata(c_tdata), .s_tvalid(c_tvalid), .s_tready(c_tready),
    .s_tlast(4'b0000), .m_tdata(c_mdata), .m_tvalid(c_mvalid), .m_tready(1'b1),
    .m_tlast(c_mlast), .err_last_mismatch(c_err));
  axis_adder_tree_nch #(.NUM_OPERANDS(2), .ADDER_WIDTH(8), .SIGNED(0), .SATURATE(1)) u_d (
    .clk(clk), .rstn(rstn), .s_tdata(d_tdata), .s_tvalid(d_tvalid), .s_tready(d_tready),
    .s_tlast(2'b00), .m_tdata(d_mdata), .m_tvalid(d_mvalid), .m_tready(1'b1),
    .m_tlast(d_mlast), .err_last_mismatch(d_err));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Integer sum of n 8-bit operands, optional clamp, truncated to the bus width.
  function automatic logic [63:0] model(input logic [31:0] ops, input int n, input bit sg,
                                        input bit sat, input int ow);
    longint s, v;
    logic [63:0] r;
    s = 0;
    for (int k = 0; k < n; k++) begin
      v = longint'(ops[k*8 +: 8]);
      if (sg && v >= 128) v = v - 256;
      s = s + v;
    end
    if (sat) begin
      if (sg) begin
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
      end else if (s > 255) begin
        s = 255;
      end
    end
    r = 64'(s);
    return r & ((64'd1 << ow) - 64'd1);
  endfunction

  // One beat into each of B, C, D; check latency and value.
  task automatic multi_beat(input logic [23:0] ob, input logic [31:0] oc, input logic [15:0] od);
    b_tdata = ob; c_tdata = oc; d_tdata = od;
    b_tvalid = '1; c_tvalid = '1; d_tvalid = '1;
    @(negedge clk);
    chk("bcd_ready", 64'({b_tready, c_tready, d_tready}), 64'(9'h1FF));
    @(posedge clk); #1;
    b_tvalid = '0; c_tvalid = '0; d_tvalid = '0;
    chk("d_valid_lat1", 64'(d_mvalid), 64'(1));
    chk("d_sum", 64'(d_mdata), model(32'(od), 2, 1'b0, 1'b1, 8));
    chk("bc_not_yet", 64'({b_mvalid, c_mvalid}), 64'(0));
    @(posedge clk); #1;
    chk("bc_valid_lat2", 64'({b_mvalid, c_mvalid}), 64'(2'b11));
    chk("b_sum", 64'(b_mdata), model(32'(ob), 3, 1'b1, 1'b0, 16));
    chk("c_sum", 64'(c_mdata), model(oc, 4, 1'b1, 1'b1, 8));
    chk("bcd_side", 64'({b_mlast, c_mlast, d_mlast, b_err, c_err, d_err}), 64'(0));
  endtask

  logic [63:0] q_data[$];
  logic        q_last[$];
  bit          exp_err;
  bit          exp_rdy;
  logic [31:0] tmp;

  initial begin
    rstn = 1'b1;
    a_tdata = '0; a_tvalid = '1; a_tlast = '0; a_mready = 1'b1;
    b_tdata = '0; b_tvalid = '0; c_tdata = '0; c_tvalid = '0; d_tdata = '0; d_tvalid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_out", 64'({a_mvalid, a_mdata, a_mlast, a_err}), 64'(0));
    chk("rst_a_ready", 64'(a_tready), 64'(0));
    chk("rst_bcd_valid", 64'({b_mvalid, c_mvalid, d_mvalid}), 64'(0));
    a_tvalid = '0;
    rstn = 1'b0;
    @(posedge clk); #1;

    // All-ones unsigned sum and two-cycle latency
    a_tdata = 32'hFFFF_FFFF; a_tvalid = '1;
    @(negedge clk);
    chk("ff_ready", 64'(a_tready), 64'(4'hF));
    @(posedge clk); #1;
    a_tvalid = '0;
    chk("ff_lat_early", 64'(a_mvalid), 64'(0));
    @(posedge clk); #1;
    chk("ff_valid", 64'(a_mvalid), 64'(1));
    chk("ff_sum", 64'(a_mdata), 64'(16'h03FC));
    @(posedge clk); #1;
    chk("ff_single", 64'(a_mvalid), 64'(0));

    // Join with channel 2 late, tlast non-uniform
    tmp = $urandom;
    a_tdata = tmp; a_tlast = 4'b0001; a_tvalid = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("join_hold", 64'(a_tready), 64'(0));
      @(posedge clk); #1;
    end
    a_tvalid = 4'hF;
    @(negedge clk);
    chk("join_fire", 64'(a_tready), 64'(4'hF));
    @(posedge clk); #1;
    a_tvalid = '0;
    chk("err_pulse", 64'(a_err), 64'(1));
    @(posedge clk); #1;
    chk("join_valid", 64'(a_mvalid), 64'(1));
    chk("join_sum", 64'(a_mdata), model(tmp, 4, 1'b0, 1'b0, 16));
    chk("join_last", 64'(a_mlast), 64'(1));
    chk("err_one_cycle", 64'(a_err), 64'(0));
    @(posedge clk); #1;
    chk("join_single", 64'(a_mvalid), 64'(0));
    a_tlast = '0;

    // B/C/D directed vectors then random
    multi_beat(24'h808080, 32'h64646464, 16'h64C8);
    multi_beat(24'hFF017F, 32'h9C9C9C9C, 16'hFFFF);
    for (int i = 0; i < 6; i++) multi_beat(24'($urandom), $urandom, 16'($urandom));

    // Random stream on A with backpressure and a 5-cycle stall
    exp_err = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      a_tvalid = ($urandom % 8 != 0) ? 4'hF : 4'($urandom);
      a_tdata  = $urandom;
      a_tlast  = ($urandom % 4 == 0) ? 4'($urandom) : (($urandom % 2 != 0) ? 4'hF : 4'h0);
      if (cyc >= 40 && cyc < 45)       a_mready = 1'b0;
      else if (cyc >= 100 && cyc < 200) a_mready = ($urandom % 3 != 0);
      else                             a_mready = 1'b1;
      @(negedge clk);
      exp_rdy = (&a_tvalid) && (a_mready || q_data.size() < 2);
      chk("stream_ready", 64'(a_tready), 64'({4{exp_rdy}}));
      chk("stream_err", 64'(a_err), 64'(exp_err));
      if (a_mvalid) begin
        if (q_data.size() == 0) begin
          chk("spurious_out", 64'(a_mvalid), 64'(0));
        end else begin
          chk("stream_sum", 64'(a_mdata), q_data[0]);
          chk("stream_last", 64'(a_mlast), 64'(q_last[0]));
          if (a_mready) begin
            void'(q_data.pop_front());
            void'(q_last.pop_front());
          end
        end
      end
      if ((&a_tvalid) && a_tready[0]) begin
        q_data.push_back(model(a_tdata, 4, 1'b0, 1'b0, 16));
        q_last.push_back(a_tlast[0]);
        exp_err = (|a_tlast) && !(&a_tlast);
      end else begin
        exp_err = 1'b0;
      end
      @(posedge clk); #1;
    end
    a_tvalid = '0; a_mready = 1'b1;
    for (int i = 0; i < 20 && q_data.size() != 0; i++) begin
      @(negedge clk);
      if (a_mvalid) begin
        chk("drain_sum", 64'(a_mdata), q_data[0]);
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q_data.size()), 64'(0));

    // Reset with two beats in flight
    a_mready = 1'b0; a_tvalid = 4'hF; a_tdata = $urandom;
    @(posedge clk); #1;
    a_tdata = $urandom;
    @(posedge clk); #1;
    a_tvalid = '0;
    chk("inflight_valid", 64'(a_mvalid), 64'(1));
    #2 rstn = 1'b1; a_tvalid = 4'hF;
    #1;
    chk("midrst_out", 64'({a_mvalid, a_mdata}), 64'(0));
    chk("midrst_ready", 64'(a_tready), 64'(0));
    @(negedge clk);
    rstn = 1'b0; a_tvalid = '0; a_mready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale", 64'(a_mvalid), 64'(0));
    end
    tmp = $urandom;
    a_tdata = tmp; a_tvalid = 4'hF;
    @(posedge clk); #1;
    a_tvalid = '0;
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(a_mvalid), 64'(1));
    chk("post_rst_sum", 64'(a_mdata), model(tmp, 4, 1'b0, 1'b0, 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
